mci_mcu_trace_capture_ctrl: RTL and testbench

MCI_MCU_TRACE_CAPTURE_CTRL -- requirements
Module: mci_mcu_trace_capture_ctrl

---
 rtl/mci_mcu_trace_capture_ctrl.sv | 125 ++++++++++++
 tb/tb_mci_mcu_trace_capture_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mci_mcu_trace_capture_ctrl.sv
// MCU trace capture controller.
// Qualifies the MCU trace stream into the trace-buffer write enable.
// Either every unlocked packet passes straight through (bypass), or an
// arm/trigger/post-count state machine decides which packets are kept.
module mci_mcu_trace_capture_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 debug_en,
    input  logic                 cfg_enable,
    input  logic                 cfg_arm,
    input  logic                 cfg_clear,
    input  logic [31:0]          cfg_trig_addr,
    input  logic [31:0]          cfg_trig_mask,
    input  logic                 cfg_trig_on_exc,
    input  logic [CNT_WIDTH-1:0] cfg_post_count,
    input  logic                 trace_valid_i,
    input  logic [31:0]          trace_addr_i,
    input  logic                 trace_exc_i,
    output logic                 trace_valid_o,
    output logic [1:0]           state_o,
    output logic                 triggered_o,
    output logic [31:0]          trig_addr_o,
    output logic [CNT_WIDTH-1:0] capture_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t                 state;
    logic                   triggered;
    logic [31:0]            trig_addr;
    logic [CNT_WIDTH-1:0]   capture_cnt;
    logic [CNT_WIDTH-1:0]   post_rem;

    logic                   capturing;
    logic                   addr_match;
    logic                   exc_hit;
    logic                   hit;
    logic                   write_en;

    // Trigger detection and the zero-latency write qualifier; the write is
    // always gated by the state as it stands before the clock edge.
    always_comb begin
        addr_match = (((trace_addr_i ^ cfg_trig_addr) & cfg_trig_mask) == 32'd0);
        exc_hit    = cfg_trig_on_exc & trace_exc_i;
        hit        = trace_valid_i & (addr_match | exc_hit);
        capturing  = (state == ST_ARMED) || (state == ST_POST);
        write_en   = trace_valid_i & debug_en & (~cfg_enable | capturing);
    end

    assign trace_valid_o = write_en;
    assign state_o       = state;
    assign triggered_o   = triggered;
    assign trig_addr_o   = trig_addr;
    assign capture_cnt_o = capture_cnt;

    // Capture FSM with its counters and trigger record; priority is
    // debug lock, then clear, then arm, then trigger/post-count progress.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= ST_IDLE;
            triggered   <= 1'b0;
            trig_addr   <= 32'd0;
            capture_cnt <= CNT_ZERO;
            post_rem    <= CNT_ZERO;
        end else if (!debug_en) begin
            // Locked: drop back to IDLE but keep the trigger record for readout.
            state <= ST_IDLE;
        end else if (!cfg_enable) begin
            // Bypass: FSM parked, counters and flags left as they are.
            state <= ST_IDLE;
        end else if (cfg_clear) begin
            state       <= ST_IDLE;
            triggered   <= 1'b0;
            trig_addr   <= 32'd0;
            capture_cnt <= CNT_ZERO;
            post_rem    <= CNT_ZERO;
        end else if (cfg_arm) begin
            state       <= ST_ARMED;
            triggered   <= 1'b0;
            trig_addr   <= 32'd0;
            capture_cnt <= CNT_ZERO;
            post_rem    <= CNT_ZERO;
        end else begin
            if (write_en && (capture_cnt != CNT_MAX)) begin
                capture_cnt <= capture_cnt + CNT_ONE;
            end
            case (state)
                ST_ARMED: begin
                    if (hit) begin
                        triggered <= 1'b1;
                        trig_addr <= trace_addr_i;
                        post_rem  <= cfg_post_count;
                        state     <= (cfg_post_count == CNT_ZERO) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (write_en) begin
                        // The <= guard keeps post_rem from wrapping below zero.
                        if (post_rem <= CNT_ONE) begin
                            post_rem <= CNT_ZERO;
                            state    <= ST_DONE;
                        end else begin
                            post_rem <= post_rem - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mci_mcu_trace_capture_ctrl.sv
// Testbench for mci_mcu_trace_capture_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_mci_mcu_trace_capture_ctrl;

    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          debug_en;
    logic          cfg_enable;
    logic          cfg_arm;
    logic          cfg_clear;
    logic [31:0]   cfg_trig_addr;
    logic [31:0]   cfg_trig_mask;
    logic          cfg_trig_on_exc;
    logic [CW-1:0] cfg_post_count;
    logic          trace_valid_i;
    logic [31:0]   trace_addr_i;
    logic          trace_exc_i;
    logic          trace_valid_o;
    logic [1:0]    state_o;
    logic          triggered_o;
    logic [31:0]   trig_addr_o;
    logic [CW-1:0] capture_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 armed, 2 post, 3 done.
    int          m_mode;
    bit          m_trig;
    logic [31:0] m_taddr;
    int          m_cnt;
    int          m_rem;

    mci_mcu_trace_capture_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .debug_en       (debug_en),
        .cfg_enable     (cfg_enable),
        .cfg_arm        (cfg_arm),
        .cfg_clear      (cfg_clear),
        .cfg_trig_addr  (cfg_trig_addr),
        .cfg_trig_mask  (cfg_trig_mask),
        .cfg_trig_on_exc(cfg_trig_on_exc),
        .cfg_post_count (cfg_post_count),
        .trace_valid_i  (trace_valid_i),
        .trace_addr_i   (trace_addr_i),
        .trace_exc_i    (trace_exc_i),
        .trace_valid_o  (trace_valid_o),
        .state_o        (state_o),
        .triggered_o    (triggered_o),
        .trig_addr_o    (trig_addr_o),
        .capture_cnt_o  (capture_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_trig  = 0;
        m_taddr = 32'd0;
        m_cnt   = 0;
        m_rem   = 0;
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, ".state"}, 64'(state_o), 64'(m_mode));
        check_eq({tag, ".trig"}, 64'(triggered_o), 64'(m_trig));
        check_eq({tag, ".taddr"}, 64'(trig_addr_o), 64'(m_taddr));
        check_eq({tag, ".cnt"}, 64'(capture_cnt_o), 64'(m_cnt));
    endtask

    // Called at a negedge with inputs already set: checks the write enable,
    // advances the model across one rising edge and checks the registers.
    task automatic tick(input string tag);
        bit wr;
        bit hit;
        #1;
        wr  = trace_valid_i && debug_en && (!cfg_enable || m_mode == 1 || m_mode == 2);
        hit = trace_valid_i && ((((trace_addr_i ^ cfg_trig_addr) & cfg_trig_mask) == 32'd0)
                                || (trace_exc_i && cfg_trig_on_exc));
        check_eq({tag, ".wr"}, 64'(trace_valid_o), 64'(wr));
        if (!debug_en || !cfg_enable) begin
            m_mode = 0;
        end else if (cfg_clear) begin
            model_reset();
        end else if (cfg_arm) begin
            model_reset();
            m_mode = 1;
        end else begin
            if (wr) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
            if (m_mode == 1 && hit) begin
                m_trig  = 1;
                m_taddr = trace_addr_i;
                m_rem   = int'(cfg_post_count);
                m_mode  = (m_rem == 0) ? 3 : 2;
            end else if (m_mode == 2 && wr) begin
                m_rem = m_rem - 1;
                if (m_rem <= 0) begin
                    m_rem  = 0;
                    m_mode = 3;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_regs(tag);
        cfg_arm   = 1'b0;
        cfg_clear = 1'b0;
    endtask

    task automatic pkt(input string tag, input logic v, input logic [31:0] a, input logic e);
        trace_valid_i = v;
        trace_addr_i  = a;
        trace_exc_i   = e;
        tick(tag);
    endtask

    task automatic do_arm(input string tag);
        cfg_arm = 1'b1;
        pkt(tag, 1'b0, 32'd0, 1'b0);
    endtask

    // Asynchronous reset taken at a negedge; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        rst_b = 1'b0;
        #1;
        model_reset();
        check_eq({tag, ".rst_wr"}, 64'(trace_valid_o), 64'((!cfg_enable) & trace_valid_i & debug_en));
        check_regs({tag, ".rst"});
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        int writes;
        rst_b           = 1'b0;
        debug_en        = 1'b1;
        cfg_enable      = 1'b1;
        cfg_arm         = 1'b0;
        cfg_clear       = 1'b0;
        cfg_trig_addr   = 32'h8000_0100;
        cfg_trig_mask   = 32'hFFFF_FFFF;
        cfg_trig_on_exc = 1'b0;
        cfg_post_count  = 4'd3;
        trace_valid_i   = 1'b1;
        trace_addr_i    = 32'h8000_0100;
        trace_exc_i     = 1'b0;
        model_reset();

        // Reset state, gated mode with valid high
        repeat (2) @(negedge clk);
        check_eq("reset.wr", 64'(trace_valid_o), 64'd0);
        check_regs("reset");
        rst_b = 1'b1;

        // Arm, pre-trigger history, trigger at 0x8000_0100, three post packets
        do_arm("s1.arm");
        pkt("s1.p0", 1'b1, 32'h8000_00F0, 1'b0);
        pkt("s1.p1", 1'b1, 32'h8000_00F8, 1'b0);
        pkt("s1.trg", 1'b1, 32'h8000_0100, 1'b0);
        for (int i = 0; i < 5; i++) pkt("s1.post", 1'b1, 32'h8000_0104 + 32'(4 * i), 1'b0);
        check_eq("s1.cnt6", 64'(capture_cnt_o), 64'd6);
        check_eq("s1.done", 64'(state_o), 64'd3);
        check_eq("s1.taddr", 64'(trig_addr_o), 64'h8000_0100);

        // Re-arm clears counters and flags
        do_arm("s2.rearm");
        check_eq("s2.cnt0", 64'(capture_cnt_o), 64'd0);
        check_eq("s2.trig0", 64'(triggered_o), 64'd0);
        check_eq("s2.armed", 64'(state_o), 64'd1);

        // Zero post count: the trigger is the only write
        cfg_post_count = 4'd0;
        pkt("s3.trg", 1'b1, 32'h8000_0100, 1'b0);
        check_eq("s3.done", 64'(state_o), 64'd3);
        pkt("s3.frozen0", 1'b1, 32'h8000_0100, 1'b0);
        pkt("s3.frozen1", 1'b1, 32'h8000_0200, 1'b0);
        check_eq("s3.cnt1", 64'(capture_cnt_o), 64'd1);

        // Arm and clear together in DONE: clear wins
        cfg_arm   = 1'b1;
        cfg_clear = 1'b1;
        pkt("s4.armclr", 1'b0, 32'd0, 1'b0);
        check_eq("s4.idle", 64'(state_o), 64'd0);

        // Exception packet without and with exception triggering
        cfg_post_count = 4'd2;
        do_arm("s5.arm");
        pkt("s5.noexc", 1'b1, 32'h0000_1234, 1'b1);
        check_eq("s5.notrig", 64'(triggered_o), 64'd0);
        cfg_trig_on_exc = 1'b1;
        pkt("s5.exc", 1'b1, 32'h0000_1234, 1'b1);
        check_eq("s5.trig", 64'(triggered_o), 64'd1);
        cfg_trig_on_exc = 1'b0;

        // Debug lock dropped in POST with a valid packet
        cfg_post_count = 4'd5;
        do_arm("s6.arm");
        pkt("s6.trg", 1'b1, 32'h8000_0100, 1'b0);
        debug_en = 1'b0;
        pkt("s6.lock", 1'b1, 32'h8000_0104, 1'b0);
        check_eq("s6.idle", 64'(state_o), 64'd0);
        check_eq("s6.keep", 64'(trig_addr_o), 64'h8000_0100);
        debug_en = 1'b1;

        // Arm with a matching packet from IDLE: armed, not triggered
        cfg_arm = 1'b1;
        pkt("s7.armhit", 1'b1, 32'h8000_0100, 1'b0);
        check_eq("s7.armed", 64'(state_o), 64'd1);
        check_eq("s7.notrig", 64'(triggered_o), 64'd0);

        // Bypass: ten valids all written, FSM held in IDLE
        cfg_enable = 1'b0;
        writes = 0;
        for (int i = 0; i < 10; i++) begin
            trace_valid_i = 1'b1;
            trace_addr_i  = 32'h4000_0000 + 32'(i);
            #1;
            if (trace_valid_o) writes++;
            tick("s8.byp");
        end
        check_eq("s8.writes", 64'(writes), 64'd10);
        check_eq("s8.idle", 64'(state_o), 64'd0);
        cfg_enable = 1'b1;

        // Zero mask hits on every packet; counter saturates
        cfg_trig_mask  = 32'd0;
        cfg_post_count = 4'd15;
        do_arm("s9.arm");
        for (int i = 0; i < 20; i++) pkt("s9.pkt", 1'b1, $urandom, 1'b0);
        check_eq("s9.sat", 64'(capture_cnt_o), 64'(CMAX));
        check_eq("s9.done", 64'(state_o), 64'd3);

        // Asynchronous reset mid-POST; nothing written afterwards
        cfg_trig_mask  = 32'hFFFF_FFFF;
        cfg_post_count = 4'd5;
        do_arm("s10.arm");
        pkt("s10.trg", 1'b1, 32'h8000_0100, 1'b0);
        pkt("s10.post", 1'b1, 32'h8000_0104, 1'b0);
        trace_valid_i = 1'b1;
        async_reset("s10");
        for (int i = 0; i < 3; i++) pkt("s10.after", 1'b1, 32'h8000_0100, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            debug_en        = ($urandom_range(0, 19) != 0);
            cfg_enable      = ($urandom_range(0, 9) != 0);
            cfg_arm         = ($urandom_range(0, 24) == 0);
            cfg_clear       = ($urandom_range(0, 39) == 0);
            cfg_post_count  = CW'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) cfg_trig_on_exc = 1'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 2))
                    0:       cfg_trig_mask = 32'hFFFF_FFFF;
                    1:       cfg_trig_mask = 32'hFFFF_FF00;
                    default: cfg_trig_mask = 32'd0;
                endcase
            end
            if ($urandom_range(0, 299) == 0) begin
                trace_valid_i = 1'($urandom);
                async_reset("rnd");
            end
            pkt("rnd", 1'($urandom), 32'h8000_00F0 + 32'($urandom_range(0, 7) << 3),
                ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
